// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shifter with load and serial valid/ready handshakes
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             last,
  output logic             busy
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             beat;

  assign sout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign last       = (state == SHIFT) && (cnt == '0);
  // Accepting on the last beat lets a new frame follow without a bubble.
  assign load_ready = (state == IDLE) || (last && sout_ready);
  assign load       = load_valid && load_ready;
  assign beat       = sout_valid && sout_ready;
  assign sout       = sout_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= pin;
            cnt   <= CNT_TOP;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (cnt != '0) begin
              shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
              cnt   <= cnt - 1'b1;
            end else if (load_valid) begin
              shreg <= pin;
              cnt   <= CNT_TOP;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench driving an MSB-first and an LSB-first serializer in lockstep
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin;
  logic       load_valid;
  logic       sout_ready;

  logic load_ready_m, sout_m, sout_valid_m, last_m, busy_m;
  logic load_ready_l, sout_l, sout_valid_l, last_l, busy_l;

  int tests = 0;
  int fails = 0;
  int valid_cycles = 0;
  int cyc;
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic [1:0] em, el;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid), .load_ready(load_ready_m),
    .sout(sout_m), .sout_valid(sout_valid_m), .sout_ready(sout_ready), .last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid), .load_ready(load_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .sout_ready(sout_ready), .last(last_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {bit, last} pairs for both bit orders, pushed when a word is issued.
  task automatic push_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      qm.push_back({w[3-i], (i == 3) ? 1'b1 : 1'b0});
      ql.push_back({w[i],   (i == 3) ? 1'b1 : 1'b0});
    end
  endtask

  always @(negedge clk) begin
    if (sout_valid_m && sout_ready) begin
      if (qm.size() == 0) check("m_unexpected_beat", 1, 0);
      else begin
        em = qm.pop_front();
        check("m_beat", {30'd0, sout_m, last_m}, {30'd0, em});
      end
    end else if (!sout_valid_m) begin
      check("m_idle_out", {30'd0, sout_m, last_m}, 0);
    end
    if (sout_valid_l && sout_ready) begin
      if (ql.size() == 0) check("l_unexpected_beat", 1, 0);
      else begin
        el = ql.pop_front();
        check("l_beat", {30'd0, sout_l, last_l}, {30'd0, el});
      end
    end else if (!sout_valid_l) begin
      check("l_idle_out", {30'd0, sout_l, last_l}, 0);
    end
    if (sout_valid_m) valid_cycles++;
  end

  task automatic wait_load_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready_m && n < 50);
    if (!load_ready_m) check("load_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] w);
    push_word(w);
    pin        = w;
    load_valid = 1'b1;
    wait_load_ready();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    @(negedge clk);
    while (busy_m && c < 100) begin
      c++;
      @(negedge clk);
    end
    if (busy_m) check("idle_timeout", 1, 0);
  endtask

  initial begin
    rst        = 1'b0;
    pin        = 4'b0000;
    load_valid = 1'b0;
    sout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sout_valid", sout_valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_last", last_m, 0);
    check("rst_load_ready", load_ready_m, 1);
    @(posedge clk); #1 rst = 1'b1;

    // Single frame
    @(posedge clk); #1 valid_cycles = 0;
    load_word(4'b1110);
    wait_idle(cyc);
    check("t1_busy_cycles", cyc, 4);
    check("t1_valid_cycles", valid_cycles, 4);
    check("t1_load_ready_after", load_ready_m, 1);
    check("t1_busy_after", busy_l, 0);

    // Backpressure after the first beat
    @(posedge clk); #1 valid_cycles = 0;
    load_word(4'b1010);
    @(posedge clk); #1 sout_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t2_stall_sout_m", sout_m, 0);
      check("t2_stall_sout_l", sout_l, 1);
      check("t2_stall_valid", sout_valid_m, 1);
      check("t2_stall_last", last_m, 0);
      check("t2_stall_load_ready", load_ready_m, 0);
    end
    @(posedge clk); #1 sout_ready = 1'b1;
    wait_idle(cyc);
    check("t2_valid_cycles", valid_cycles, 6);
    check("t2_queue_m_empty", qm.size(), 0);

    // Back-to-back frames
    @(posedge clk); #1 valid_cycles = 0;
    push_word(4'b0011);
    push_word(4'b1010);
    pin        = 4'b0011;
    load_valid = 1'b1;
    wait_load_ready();
    pin = 4'b1010;
    wait_load_ready();
    load_valid = 1'b0;
    wait_idle(cyc);
    check("t3_tail_cycles", cyc, 4);
    check("t3_valid_cycles", valid_cycles, 8);
    check("t3_queue_l_empty", ql.size(), 0);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    load_word(4'b1110);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_async_sout_valid", sout_valid_m, 0);
    check("t5_async_sout", sout_m, 0);
    check("t5_async_last", last_m, 0);
    check("t5_async_busy", busy_l, 0);
    check("t5_beats_left", qm.size(), 2);
    qm.delete();
    ql.delete();
    @(posedge clk); #1 rst = 1'b1;
    load_word(4'b0101);
    wait_idle(cyc);
    check("t5_frame_cycles", cyc, 4);

    // Load held while in reset
    @(posedge clk); #1;
    rst        = 1'b0;
    pin        = 4'b1111;
    load_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_rst_busy", busy_m, 0);
      check("t6_rst_valid", sout_valid_l, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    push_word(4'b1111);
    @(negedge clk);
    check("t6_not_yet_busy", busy_m, 0);
    @(posedge clk); #1 load_valid = 1'b0;
    @(negedge clk);
    check("t6_first_bit_valid", sout_valid_m, 1);
    wait_idle(cyc);
    check("t6_rest_cycles", cyc, 3);

    check("end_queue_m", qm.size(), 0);
    check("end_queue_l", ql.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
